// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the core datapath and a handshaked, multi-cycle data memory.
// Builds byte strobes, lane-aligns stores, extends loads, stalls the core and flags bad accesses/timeouts.
module lsu_mem_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [31:0]      rdata_q;
  logic             fault_q;

  logic        req;
  logic        illegal_f3;
  logic        misaligned;
  logic        legal;
  logic        is_idle;
  logic        req_bad;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode the request; a simultaneous read and write is never legal.
  assign req        = req_read | req_write;
  assign illegal_f3 = req_read ? ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11))
                               : (req_funct3 >= 3'b011);
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign legal      = req && !(req_read && req_write) && !illegal_f3 && !misaligned;

  // Gating with reset keeps the combinational IDLE responses quiet while reset is held.
  assign is_idle    = reset && (state == S_IDLE);
  assign req_bad    = is_idle && req && !legal;

  assign stall      = (is_idle && legal) || (state == S_WAIT);
  assign resp_valid = req_bad || (state == S_RESP);
  assign fault      = req_bad || ((state == S_RESP) && fault_q);
  assign resp_rdata = (state == S_RESP) ? rdata_q : 32'h0;

  always_comb begin
    st_strb = 4'b1111;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << req_addr[1:0];
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  // Load extraction uses the latched offset and funct3, since the core may move on after RESP.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      rdata_q   <= 32'h0;
      fault_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (legal) begin
            state     <= S_WAIT;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= req_write;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_write ? st_data : 32'h0;
            mem_wstrb <= req_write ? st_strb : 4'b0000;
            off_q     <= req_addr[1:0];
            f3_q      <= req_funct3;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            state   <= S_RESP;
            mem_req <= 1'b0;
            rdata_q <= mem_we ? 32'h0 : ld_data;
            fault_q <= 1'b0;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            state   <= S_RESP;
            mem_req <= 1'b0;
            rdata_q <= 32'h0;
            fault_q <= 1'b1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Load/store unit between the core datapath (ALU address, rs2 data, mem_read/mem_write, funct3) and a multi-cycle handshaked data memory.
- Replaces the fixed single-cycle data-memory path.
- Generates byte strobes, lane-aligns store data, sign/zero-extends load data, and stalls the core until the access completes.
- Detects misaligned/illegal accesses and memory timeouts.

Parameters:
- TIMEOUT, 16: max WAIT cycles before abort; 0 disables timeout.
- CNT_W, 5: timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_read  input  1  load request (mem_read)
- req_write  input  1  store request (mem_write)
- req_funct3  input  3  instr[14:12]
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data (rs2)
- stall  output  1  hold PC/regfile write this cycle
- resp_valid  output  1  access complete this cycle
- resp_rdata  output  32  extended load data
- fault  output  1  misaligned/illegal access, or timeout
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  write enable
- mem_addr  output  32  word address ({req_addr[31:2],2'b00})
- mem_wdata  output  32  lane-aligned store data
- mem_wstrb  output  4  byte strobes
- mem_ack  input  1  memory done; mem_rdata valid when read
- mem_rdata  input  32  memory read word

Behaviour:
Request decode
- req = req_read|req_write. req_read&req_write both 1 is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Illegal funct3: loads 011/110/111; stores >=011.

State machine: IDLE, WAIT, RESP.
- IDLE, legal req:
  - stall=1 combinationally, same cycle.
  - At the edge, latch addr, funct3, we, wdata and strobes.
  - Set mem_req=1 (registered), clear the counter, go to WAIT.
- IDLE, illegal/misaligned req:
  - fault=1 and resp_valid=1 combinationally; stall=0, no memory access, stay IDLE.
- WAIT:
  - stall=1; mem_req held; mem_* outputs stable.
  - Counter increments each cycle.
  - mem_ack=1: capture extended read data (0 for stores), mem_req=0 at the edge, go to RESP.
  - Counter reaches TIMEOUT-1 without ack (TIMEOUT>0): mem_req=0, resp_rdata=0, set fault, go to RESP.
  - ack and timeout in the same cycle: ack wins, no fault.
- RESP:
  - stall=0, resp_valid=1 for exactly one cycle; resp_rdata and fault valid.
  - Always returns to IDLE. The still-present request from the same instruction is never relaunched.
- Latency: a load/store whose ack arrives N cycles after mem_req rises stalls N+1 cycles, then RESP.
- mem_ack in IDLE or RESP is ignored.

Store lanes (o = addr[1:0])
- SB: wstrb = 4'b0001<<o; wdata = byte replicated x4.
- SH: wstrb = 4'b0011<<o; wdata = half replicated x2.
- SW: wstrb = 4'b1111; wdata = rs2.

Load extension
- LB/LBU: byte lane o, sign/zero extended.
- LH/LHU: halfword lane o[1], sign/zero extended.
- LW: full word.

Reset
- Asynchronous: reset low at any time (including mid-WAIT) forces IDLE immediately.
- mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, counter=0.
- resp_valid=0, resp_rdata=0, fault=0, stall=0.
- No request is launched until the first edge after reset goes high.

Test Plan:
- LB from addr 0x103, mem_rdata=0x80AA_BBCC, ack 2 cycles after mem_req -> mem_addr=0x100, stall for 3 cycles, then resp_valid=1 one cycle, resp_rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH rs2=0x1234_ABCD to 0x0006 -> mem_we=1, mem_addr=0x4, wstrb=4'b1100, mem_wdata=0xABCD_ABCD; resp_rdata=0.
- LW at 0x0002, or funct3=011 load -> fault=1, resp_valid=1, stall=0 same cycle, mem_req never rises.
- TIMEOUT=16, never ack -> mem_req high 16 cycles then drops; RESP with fault=1, resp_rdata=0; ack arriving on cycle 16 -> no fault.
- Reset low 2 cycles into WAIT -> mem_req and stall drop asynchronously, not waiting for a clock edge; after release with req held -> fresh access from IDLE.
- Back-to-back loads: RESP then IDLE accepts the next request next cycle; mem_ack pulse during IDLE has no effect.
